// File: rtl/aes_dec_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_ctrl
// Sequencing controller for the AES-128 inverse-cipher datapath. A start
// request loads the ciphertext, waits for key expansion and then walks the
// shared state register through AddRoundKey / InvShiftRows / InvSubBytes /
// InvMixColumns for rounds 10..0. Only control lives here: FSM, round counter,
// InvMixColumns column counter and key-expansion wait counter.
//
// Ports
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous active-high reset (forces IDLE, outputs 0)
//   start     in   level request, sampled only in IDLE and DONE
//   init_ld   out  load ciphertext into the state register
//   state_ld  out  write selected op result into the state register
//   op_sel    out  0 none, 1 AddRoundKey, 2 InvShiftRows, 3 InvSubBytes,
//                  4 InvMixColumns
//   rk_idx    out  round-key index during AddRoundKey, 0 otherwise
//   imc_col   out  column fed to InvMixColumns, 0 otherwise
//   busy      out  high in every state except IDLE and DONE
//   done      out  high only in DONE
// -----------------------------------------------------------------------------
module aes_dec_ctrl #(
  parameter int unsigned KEYEXP_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       init_ld,
  output logic       state_ld,
  output logic [2:0] op_sel,
  output logic [3:0] rk_idx,
  output logic [1:0] imc_col,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_KEYEXP = 4'd2,
    S_ARK0   = 4'd3,
    S_ISR    = 4'd4,
    S_ISB_RD = 4'd5,
    S_ISB_WR = 4'd6,
    S_ARK    = 4'd7,
    S_IMC    = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ARK  = 3'd1;
  localparam logic [2:0] OP_ISR  = 3'd2;
  localparam logic [2:0] OP_ISB  = 3'd3;
  localparam logic [2:0] OP_IMC  = 3'd4;

  // Wait counter runs 0..KEYEXP_CYCLES-1 while in KEYEXP.
  localparam logic [7:0] WAIT_LAST = 8'(KEYEXP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q,  wait_d;
  logic [3:0] rnd_q,   rnd_d;
  logic [1:0] col_q,   col_d;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 8'd0;
      rnd_q   <= 4'd0;
      col_q   <= 4'd0 == 4'd0 ? 2'd0 : 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rnd_q   <= rnd_d;
      col_q   <= col_d;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    rnd_d   = rnd_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        wait_d  = 8'd0;
        state_d = S_KEYEXP;
      end
      S_KEYEXP: begin
        if (wait_q == WAIT_LAST) state_d = S_ARK0;
        else                     wait_d  = wait_q + 8'd1;
      end
      S_ARK0: begin
        rnd_d   = 4'd9;
        state_d = S_ISR;
      end
      S_ISR:    state_d = S_ISB_RD;
      S_ISB_RD: state_d = S_ISB_WR;
      S_ISB_WR: state_d = S_ARK;
      S_ARK: begin
        // Final round skips InvMixColumns.
        if (rnd_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          col_d   = 2'd0;
          state_d = S_IMC;
        end
      end
      S_IMC: begin
        if (col_q == 2'd3) begin
          // Guard keeps the round counter from ever wrapping.
          if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
          state_d = S_ISR;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    init_ld  = 1'b0;
    state_ld = 1'b0;
    op_sel   = OP_NONE;
    rk_idx   = 4'd0;
    imc_col  = 2'd0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE:   busy = 1'b0;
      S_LOAD:   init_ld = 1'b1;
      S_KEYEXP: op_sel = OP_NONE;
      S_ARK0: begin
        op_sel   = OP_ARK;
        rk_idx   = 4'd10;
        state_ld = 1'b1;
      end
      S_ISR: begin
        op_sel   = OP_ISR;
        state_ld = 1'b1;
      end
      // S-box bank has one cycle of read latency; write on the next cycle.
      S_ISB_RD: op_sel = OP_ISB;
      S_ISB_WR: begin
        op_sel   = OP_ISB;
        state_ld = 1'b1;
      end
      S_ARK: begin
        op_sel   = OP_ARK;
        rk_idx   = rnd_q;
        state_ld = 1'b1;
      end
      S_IMC: begin
        op_sel   = OP_IMC;
        imc_col  = col_q;
        state_ld = 1'b1;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
module tb_aes_dec_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic sel;

  logic       a_init_ld, a_state_ld, a_busy, a_done;
  logic [2:0] a_op_sel;
  logic [3:0] a_rk_idx;
  logic [1:0] a_imc_col;

  logic       b_init_ld, b_state_ld, b_busy, b_done;
  logic [2:0] b_op_sel;
  logic [3:0] b_rk_idx;
  logic [1:0] b_imc_col;

  logic       m_init_ld, m_state_ld, m_busy, m_done;
  logic [2:0] m_op_sel;
  logic [3:0] m_rk_idx;
  logic [1:0] m_imc_col;

  int checks = 0;
  int errors = 0;

  int done_at, busy_cnt, sl_cnt, ark_cnt, imc_cnt, rk_left;

  always #5 clk = ~clk;

  aes_dec_ctrl dut (
    .clk(clk), .reset(reset), .start(start0),
    .init_ld(a_init_ld), .state_ld(a_state_ld), .op_sel(a_op_sel),
    .rk_idx(a_rk_idx), .imc_col(a_imc_col), .busy(a_busy), .done(a_done)
  );

  aes_dec_ctrl #(.KEYEXP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .init_ld(b_init_ld), .state_ld(b_state_ld), .op_sel(b_op_sel),
    .rk_idx(b_rk_idx), .imc_col(b_imc_col), .busy(b_busy), .done(b_done)
  );

  assign m_init_ld  = sel ? b_init_ld  : a_init_ld;
  assign m_state_ld = sel ? b_state_ld : a_state_ld;
  assign m_op_sel   = sel ? b_op_sel   : a_op_sel;
  assign m_rk_idx   = sel ? b_rk_idx   : a_rk_idx;
  assign m_imc_col  = sel ? b_imc_col  : a_imc_col;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  // Start a run and trace it cycle by cycle until done (bounded).
  task automatic run(input bit toggle, output int d_at, output int b_cnt,
                     output int s_cnt, output int a_cnt, output int i_cnt,
                     output int r_left);
    int         exp_rk = 10;
    logic [1:0] exp_col = 2'd0;
    bit         seen_final = 1'b0;
    logic [2:0] prev_op = 3'd0;
    logic       prev_sl = 1'b0;
    d_at = -1; b_cnt = 0; s_cnt = 0; a_cnt = 0; i_cnt = 0;
    set_start(1'b1);
    for (int n = 0; n < 300; n++) begin
      step();
      if (toggle) set_start(n[0]);
      else        set_start(1'b0);
      chk("init_ld", {31'd0, m_init_ld}, (n == 0) ? 32'd1 : 32'd0);
      if (m_done) begin
        chk("done_quiet", {m_init_ld, m_state_ld, m_op_sel, m_rk_idx, m_imc_col, m_busy}, 32'd0);
        d_at = n;
        break;
      end
      chk("busy_run", {31'd0, m_busy}, 32'd1);
      b_cnt++;
      if (m_state_ld) s_cnt++;
      if (m_op_sel == 3'd1) begin
        chk("rk_idx_seq", {28'd0, m_rk_idx}, exp_rk);
        if (m_rk_idx == 4'd0) seen_final = 1'b1;
        exp_rk--;
        a_cnt++;
      end else begin
        chk("rk_idx_zero", {28'd0, m_rk_idx}, 32'd0);
      end
      if (m_op_sel == 3'd4) begin
        chk("imc_col_seq", {30'd0, m_imc_col}, {30'd0, exp_col});
        chk("imc_after_final", {31'd0, seen_final}, 32'd0);
        exp_col = exp_col + 2'd1;
        i_cnt++;
      end else begin
        chk("imc_col_zero", {30'd0, m_imc_col}, 32'd0);
      end
      if (m_op_sel == 3'd3 && m_state_ld)
        chk("isb_wr_after_rd", {28'd0, prev_op, prev_sl}, {28'd0, 3'd3, 1'b0});
      prev_op = m_op_sel;
      prev_sl = m_state_ld;
    end
    r_left = exp_rk;
  endtask

  initial begin
    sel    = 1'b0;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    step();
    step();
    chk("reset_outs_a", {a_init_ld, a_state_ld, a_op_sel, a_rk_idx, a_imc_col, a_busy, a_done}, 32'd0);
    chk("reset_outs_b", {b_init_ld, b_state_ld, b_op_sel, b_rk_idx, b_imc_col, b_busy, b_done}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_outs", {a_init_ld, a_state_ld, a_op_sel, a_rk_idx, a_imc_col, a_busy, a_done}, 32'd0);

    // First full run, default key-expansion wait
    run(1'b0, done_at, busy_cnt, sl_cnt, ark_cnt, imc_cnt, rk_left);
    chk("r1_done_at", done_at, 32'd88);
    chk("r1_busy_cnt", busy_cnt, 32'd88);
    chk("r1_state_ld_cnt", sl_cnt, 32'd67);
    chk("r1_ark_cnt", ark_cnt, 32'd11);
    chk("r1_imc_cnt", imc_cnt, 32'd36);
    chk("r1_rk_left", rk_left, -32'sd1);

    // Hold start through DONE, then release
    set_start(1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_done", {31'd0, a_done}, 32'd1);
      chk("hold_busy", {31'd0, a_busy}, 32'd0);
    end
    set_start(1'b0);
    step();
    chk("release_done", {31'd0, a_done}, 32'd0);
    chk("release_idle", {a_init_ld, a_state_ld, a_op_sel, a_rk_idx, a_imc_col, a_busy, a_done}, 32'd0);

    // Second identical run
    run(1'b0, done_at, busy_cnt, sl_cnt, ark_cnt, imc_cnt, rk_left);
    chk("r2_done_at", done_at, 32'd88);
    chk("r2_state_ld_cnt", sl_cnt, 32'd67);
    chk("r2_rk_left", rk_left, -32'sd1);
    step();
    chk("r2_back_idle", {31'd0, a_done}, 32'd0);

    // Reset asynchronously during round 5, InvMixColumns column 2
    set_start(1'b1);
    step();
    chk("r3_load", {31'd0, a_init_ld}, 32'd1);
    set_start(1'b0);
    repeat (50) step();
    chk("r3_imc_op", {29'd0, a_op_sel}, 32'd4);
    chk("r3_imc_col2", {30'd0, a_imc_col}, 32'd2);
    chk("r3_imc_ld", {31'd0, a_state_ld}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outs", {a_init_ld, a_state_ld, a_op_sel, a_rk_idx, a_imc_col, a_busy, a_done}, 32'd0);
    #1;
    reset = 1'b0;
    run(1'b0, done_at, busy_cnt, sl_cnt, ark_cnt, imc_cnt, rk_left);
    chk("r4_done_at", done_at, 32'd88);
    chk("r4_busy_cnt", busy_cnt, 32'd88);
    chk("r4_state_ld_cnt", sl_cnt, 32'd67);
    chk("r4_imc_cnt", imc_cnt, 32'd36);
    step();

    // One-cycle key expansion, start toggled while busy
    sel = 1'b1;
    run(1'b1, done_at, busy_cnt, sl_cnt, ark_cnt, imc_cnt, rk_left);
    chk("k1_done_at", done_at, 32'd79);
    chk("k1_busy_cnt", busy_cnt, 32'd79);
    chk("k1_state_ld_cnt", sl_cnt, 32'd67);
    chk("k1_ark_cnt", ark_cnt, 32'd11);
    chk("k1_imc_cnt", imc_cnt, 32'd36);
    chk("k1_rk_left", rk_left, -32'sd1);
    set_start(1'b0);
    step();
    chk("k1_back_idle", {31'd0, b_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
